exe_stage: RTL and testbench

- Execute stage of the 5-stage RV64 pipeline.
- Consumes the ID/EXE pipeline register outputs and resolves operand forwarding, the ALU operation and branch/jump redirects.
- Contains a multi-cycle iterative multiplier that stalls the front of the pipe.
- Ends in the EXE/MEM pipeline register, whose outputs feed the MEM stage.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/exe_stage_if.sv | 66 ++++++
 rtl/iter_mul.sv | 66 ++++++
 rtl/exe_stage.sv | 200 ++++++++++++++++++++
 tb/tb_exe_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 pipeline: datapath width, ALU operation
// encodings, forwarding-select encodings and the execute-stage FSM states.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } exe_state_e;

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage bus: ID/EXE register outputs, forwarding inputs, hazard and
// redirect outputs, and the EXE/MEM register outputs. The master side is the
// surrounding pipeline; the slave side is the execute stage itself.
interface exe_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  // ID/EXE pipeline register outputs
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            MemReadE;
  logic            MemTypeE;
  logic            ResultSrcE;
  logic [2:0]      ALUOpE;
  logic            BEQ_E;
  logic            BNE_E;
  logic            JAL_E;
  logic            JALR_E;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_E;
  logic [XLEN-1:0] PCE;
  logic [4:0]      RD_E;

  // Forwarding controls and writeback result
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  // Hazard / redirect outputs
  logic            StallE;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;

  // EXE/MEM pipeline register outputs
  logic            RegWriteM;
  logic            MemWriteM;
  logic            MemReadM;
  logic            MemTypeM;
  logic            ResultSrcM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [4:0]      RD_M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, MemReadE, MemTypeE, ResultSrcE,
    output ALUOpE, BEQ_E, BNE_E, JAL_E, JALR_E,
    output RD1_E, RD2_E, Imm_E, PCE, RD_E,
    output ForwardAE, ForwardBE, ResultW,
    input  StallE, PCSrcE, PCTargetE,
    input  RegWriteM, MemWriteM, MemReadM, MemTypeM, ResultSrcM,
    input  ALUResultM, WriteDataM, RD_M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, MemReadE, MemTypeE, ResultSrcE,
    input  ALUOpE, BEQ_E, BNE_E, JAL_E, JALR_E,
    input  RD1_E, RD2_E, Imm_E, PCE, RD_E,
    input  ForwardAE, ForwardBE, ResultW,
    output StallE, PCSrcE, PCTargetE,
    output RegWriteM, MemWriteM, MemReadM, MemTypeM, ResultSrcM,
    output ALUResultM, WriteDataM, RD_M
  );

endinterface

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier. 'start' latches the operands and clears the
// accumulator; each 'step' cycle retires MUL_BITS multiplier bits. 'done'
// pulses on the step that retires the final bits, so 'product' is valid from
// the following cycle. Only the low XLEN bits are kept, which makes the
// result identical for signed and unsigned operands.
module iter_mul #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] product,
  output logic            done
);

  localparam int MUL_ITERS = XLEN / MUL_BITS;
  localparam int CNT_W     = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [XLEN-1:0]  mcand_reg;
  logic [XLEN-1:0]  mplier_reg;
  logic [XLEN-1:0]  acc_reg;
  logic [XLEN-1:0]  acc_next;
  logic [CNT_W-1:0] count_reg;
  logic [XLEN-1:0]  partial [MUL_BITS];

  // One shifted copy of the multiplicand per multiplier bit retired this cycle
  for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_partial
    assign partial[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
  end

  // Accumulate this cycle's partial products
  always_comb begin
    acc_next = acc_reg;
    for (int i = 0; i < MUL_BITS; i++) begin
      acc_next = acc_next + partial[i];
    end
  end

  // Operand/accumulator/counter registers; reset drops any partial product
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (start) begin
      mcand_reg  <= op_a;
      mplier_reg <= op_b;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << MUL_BITS;
      mplier_reg <= mplier_reg >> MUL_BITS;
      count_reg  <= count_reg + 1'b1;
    end
  end

  assign done    = step && (count_reg == CNT_W'(MUL_ITERS - 1));
  assign product = acc_reg;

endmodule

// File: rtl/exe_stage.sv
// RV64 execute stage: operand forwarding, ALU, branch/jump resolution, an
// iterative multiplier sequenced by an IDLE/MUL/DONE FSM that stalls the
// front of the pipe, and the EXE/MEM pipeline register.
module exe_stage #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int MUL_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  exe_stage_if.slave bus
);

  import riscv_pkg::*;

  localparam int SHW = $clog2(XLEN);

  exe_state_e state_reg, state_next;

  logic [XLEN-1:0] src_a, fwd_b, src_b;
  logic [XLEN-1:0] alu_result;
  logic [SHW-1:0]  shamt;
  logic            zero;
  logic            branch_taken;
  logic            stall;
  logic            mul_start, mul_step, mul_done;
  logic            m_bubble, m_use_product;
  logic [XLEN-1:0] mul_product;

  logic            reg_write_m_reg, mem_write_m_reg, mem_read_m_reg;
  logic            mem_type_m_reg, result_src_m_reg;
  logic [XLEN-1:0] alu_result_m_reg, write_data_m_reg;
  logic [4:0]      rd_m_reg;

  logic            reg_write_m_next, mem_write_m_next, mem_read_m_next;
  logic            mem_type_m_next, result_src_m_next;
  logic [XLEN-1:0] alu_result_m_next, write_data_m_next;
  logic [4:0]      rd_m_next;

  // Forwarding muxes; the registered ALUResultM is the M-stage source
  always_comb begin
    src_a = bus.RD1_E;
    fwd_b = bus.RD2_E;
    case (bus.ForwardAE)
      FWD_W:   src_a = bus.ResultW;
      FWD_M:   src_a = alu_result_m_reg;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.ForwardBE)
      FWD_W:   fwd_b = bus.ResultW;
      FWD_M:   fwd_b = alu_result_m_reg;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.Imm_E : fwd_b;
  assign shamt = src_b[SHW-1:0];

  // Single-cycle ALU; jumps write the link address instead
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(bus.ALUOpE))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRL: alu_result = src_a >> shamt;
      default: alu_result = '0;
    endcase
    if (bus.JAL_E || bus.JALR_E) begin
      alu_result = bus.PCE + XLEN'(4);
    end
  end

  // Branch compare uses the forwarded rs2 value, never the immediate
  assign zero         = (src_a == fwd_b);
  assign branch_taken = bus.JAL_E || bus.JALR_E ||
                        (bus.BEQ_E && zero) || (bus.BNE_E && !zero);

  assign bus.PCSrcE    = (state_reg == ST_IDLE) && branch_taken;
  assign bus.PCTargetE = bus.JALR_E ? ((src_a + bus.Imm_E) & ~XLEN'(1))
                                    : (bus.PCE + bus.Imm_E);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state, stall and EXE/MEM load selection
  always_comb begin
    state_next    = state_reg;
    stall         = 1'b0;
    mul_start     = 1'b0;
    mul_step      = 1'b0;
    m_bubble      = 1'b0;
    m_use_product = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (alu_op_e'(bus.ALUOpE) == ALU_MUL) begin
          stall      = 1'b1;
          mul_start  = 1'b1;
          m_bubble   = 1'b1;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        stall    = 1'b1;
        mul_step = 1'b1;
        m_bubble = 1'b1;
        if (mul_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // ID/EXE advances on this edge, so IDLE never sees this MUL again
        m_use_product = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.StallE = stall;

  iter_mul #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_iter_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .op_a    (src_a),
    .op_b    (src_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // EXE/MEM next values: pass-through, bubble, or completed product
  always_comb begin
    reg_write_m_next  = bus.RegWriteE;
    mem_write_m_next  = bus.MemWriteE;
    mem_read_m_next   = bus.MemReadE;
    mem_type_m_next   = bus.MemTypeE;
    result_src_m_next = bus.ResultSrcE;
    alu_result_m_next = alu_result;
    write_data_m_next = fwd_b;
    rd_m_next         = bus.RD_E;
    if (m_bubble) begin
      reg_write_m_next  = 1'b0;
      mem_write_m_next  = 1'b0;
      mem_read_m_next   = 1'b0;
      mem_type_m_next   = 1'b0;
      result_src_m_next = 1'b0;
      alu_result_m_next = '0;
      write_data_m_next = '0;
      rd_m_next         = '0;
    end else if (m_use_product) begin
      alu_result_m_next = mul_product;
    end
  end

  // EXE/MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m_reg  <= 1'b0;
      mem_write_m_reg  <= 1'b0;
      mem_read_m_reg   <= 1'b0;
      mem_type_m_reg   <= 1'b0;
      result_src_m_reg <= 1'b0;
      alu_result_m_reg <= '0;
      write_data_m_reg <= '0;
      rd_m_reg         <= '0;
    end else begin
      reg_write_m_reg  <= reg_write_m_next;
      mem_write_m_reg  <= mem_write_m_next;
      mem_read_m_reg   <= mem_read_m_next;
      mem_type_m_reg   <= mem_type_m_next;
      result_src_m_reg <= result_src_m_next;
      alu_result_m_reg <= alu_result_m_next;
      write_data_m_reg <= write_data_m_next;
      rd_m_reg         <= rd_m_next;
    end
  end

  assign bus.RegWriteM  = reg_write_m_reg;
  assign bus.MemWriteM  = mem_write_m_reg;
  assign bus.MemReadM   = mem_read_m_reg;
  assign bus.MemTypeM   = mem_type_m_reg;
  assign bus.ResultSrcM = result_src_m_reg;
  assign bus.ALUResultM = alu_result_m_reg;
  assign bus.WriteDataM = write_data_m_reg;
  assign bus.RD_M       = rd_m_reg;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage. The driver pushes the expected EXE/MEM
// contents for every instruction that carries control; a monitor pops and
// compares whenever the DUT presents non-zero M control. Combinational
// outputs (branch redirect, stall) are checked directly by the driver.
module tb_exe_stage;

  import riscv_pkg::*;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] wd;
    logic [4:0]  rd;
    logic [4:0]  ctl;   // {RegWrite, MemWrite, MemRead, MemType, ResultSrc}
  } mrec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  exe_stage_if bus ();

  exe_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mrec_t exp_q[$];
  int    vectors    = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [4:0] m_ctl();
    return {bus.RegWriteM, bus.MemWriteM, bus.MemReadM, bus.MemTypeM, bus.ResultSrcM};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // br = {BEQ, BNE, JAL, JALR}
  task automatic drive(input logic [2:0] aluop, input logic [4:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                       input logic [63:0] rd1, input logic [63:0] rd2, input logic [63:0] imm,
                       input logic [4:0] rd, input logic [3:0] br, input logic [63:0] pce);
    bus.ALUOpE     = aluop;
    bus.RegWriteE  = ctl[4];
    bus.MemWriteE  = ctl[3];
    bus.MemReadE   = ctl[2];
    bus.MemTypeE   = ctl[1];
    bus.ResultSrcE = ctl[0];
    bus.ForwardAE  = fa;
    bus.ForwardBE  = fb;
    bus.ALUSrcE    = alusrc;
    bus.RD1_E      = rd1;
    bus.RD2_E      = rd2;
    bus.Imm_E      = imm;
    bus.RD_E       = rd;
    bus.BEQ_E      = br[3];
    bus.BNE_E      = br[2];
    bus.JAL_E      = br[1];
    bus.JALR_E     = br[0];
    bus.PCE        = pce;
  endtask

  task automatic idle_e();
    drive(3'b000, 5'b0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0, 4'b0, 64'h0);
  endtask

  task automatic push(input logic [63:0] alu, input logic [63:0] wd,
                      input logic [4:0] rd, input logic [4:0] ctl);
    mrec_t r;
    r.alu = alu; r.wd = wd; r.rd = rd; r.ctl = ctl;
    exp_q.push_back(r);
  endtask

  // Monitor: any non-zero M control is a retired instruction
  initial begin
    mrec_t e;
    forever begin
      @(negedge clk);
      if (bus.RegWriteM === 1'b1 || bus.MemWriteM === 1'b1 || bus.MemReadM === 1'b1 ||
          bus.MemTypeM === 1'b1 || bus.ResultSrcM === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_m_output: got alu=%h ctl=%b expected none",
                   bus.ALUResultM, m_ctl());
        end else begin
          e = exp_q.pop_front();
          chk("m_alu", bus.ALUResultM, e.alu);
          chk("m_wdata", bus.WriteDataM, e.wd);
          chk("m_rd", 64'(bus.RD_M), 64'(e.rd));
          chk("m_ctl", 64'(m_ctl()), 64'(e.ctl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [4:0] C_RW    = 5'b10000;
  localparam logic [4:0] C_LOAD  = 5'b10101;
  localparam logic [4:0] C_STORE = 5'b01010;

  initial begin
    int stall_cnt;
    int bubble_bad;

    reset = 1'b1;
    bus.ResultW = 64'h0;
    idle_e();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("reset_alu_m", bus.ALUResultM, 64'h0);
    chk("reset_wdata_m", bus.WriteDataM, 64'h0);
    chk("reset_rd_m", 64'(bus.RD_M), 64'h0);
    chk("reset_ctl_m", 64'(m_ctl()), 64'h0);
    chk("reset_stall", 64'(bus.StallE), 64'h0);

    // ADD 2+3 (immediate) then ADD forwarding the result from M
    drive(ALU_ADD, C_RW, FWD_RF, FWD_RF, 1'b1, 64'd2, 64'h55, 64'd3, 5'd1, 4'b0, 64'h0);
    push(64'd5, 64'h55, 5'd1, C_RW);
    tick();
    drive(ALU_ADD, C_RW, FWD_M, FWD_RF, 1'b1, 64'h99, 64'h0, 64'd3, 5'd2, 4'b0, 64'h0);
    push(64'd8, 64'h0, 5'd2, C_RW);
    tick();

    // SUB with B forwarded from W, and a wrapping SUB
    bus.ResultW = 64'd3;
    drive(ALU_SUB, C_RW, FWD_RF, FWD_W, 1'b0, 64'd10, 64'h77, 64'h0, 5'd3, 4'b0, 64'h0);
    push(64'd7, 64'd3, 5'd3, C_RW);
    tick();
    drive(ALU_SUB, C_RW, FWD_RF, FWD_RF, 1'b0, 64'd0, 64'd1, 64'h0, 5'd4, 4'b0, 64'h0);
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, C_RW);
    tick();

    // Logic ops
    drive(ALU_AND, C_RW, FWD_RF, FWD_RF, 1'b0, 64'hF0F0, 64'hFF00, 64'h0, 5'd5, 4'b0, 64'h0);
    push(64'hF000, 64'hFF00, 5'd5, C_RW);
    tick();
    drive(ALU_OR, C_RW, FWD_RF, FWD_RF, 1'b0, 64'hF0F0, 64'hFF00, 64'h0, 5'd6, 4'b0, 64'h0);
    push(64'hFFF0, 64'hFF00, 5'd6, C_RW);
    tick();
    drive(ALU_XOR, C_RW, FWD_RF, FWD_RF, 1'b0, 64'hF0F0, 64'hFF00, 64'h0, 5'd7, 4'b0, 64'h0);
    push(64'h0FF0, 64'hFF00, 5'd7, C_RW);
    tick();

    // Load-style control word
    drive(ALU_ADD, C_LOAD, FWD_RF, FWD_RF, 1'b1, 64'h1000, 64'hABC, 64'h10, 5'd8, 4'b0, 64'h0);
    push(64'h1010, 64'hABC, 5'd8, C_LOAD);
    tick();

    // BEQ taken, BNE not taken, BNE taken
    drive(ALU_SUB, 5'b0, FWD_RF, FWD_RF, 1'b0, 64'd7, 64'd7, 64'h20, 5'd0, 4'b1000, 64'h100);
    #1;
    chk("beq_pcsrc", 64'(bus.PCSrcE), 64'h1);
    chk("beq_target", bus.PCTargetE, 64'h120);
    chk("beq_stall", 64'(bus.StallE), 64'h0);
    tick();
    drive(ALU_SUB, 5'b0, FWD_RF, FWD_RF, 1'b0, 64'd7, 64'd7, 64'h20, 5'd0, 4'b0100, 64'h100);
    #1;
    chk("bne_equal_pcsrc", 64'(bus.PCSrcE), 64'h0);
    tick();
    drive(ALU_SUB, 5'b0, FWD_RF, FWD_RF, 1'b0, 64'd7, 64'd8, 64'h20, 5'd0, 4'b0100, 64'h100);
    #1;
    chk("bne_differ_pcsrc", 64'(bus.PCSrcE), 64'h1);
    tick();

    // JALR clears bit 0 of the target; JAL uses PC-relative target
    drive(ALU_ADD, C_RW, FWD_RF, FWD_RF, 1'b1, 64'h2003, 64'h0, 64'd4, 5'd1, 4'b0001, 64'h40);
    push(64'h44, 64'h0, 5'd1, C_RW);
    #1;
    chk("jalr_pcsrc", 64'(bus.PCSrcE), 64'h1);
    chk("jalr_target", bus.PCTargetE, 64'h2006);
    tick();
    drive(ALU_ADD, C_RW, FWD_RF, FWD_RF, 1'b1, 64'h0, 64'h0, 64'h10, 5'd1, 4'b0010, 64'h200);
    push(64'h204, 64'h0, 5'd1, C_RW);
    #1;
    chk("jal_pcsrc", 64'(bus.PCSrcE), 64'h1);
    chk("jal_target", bus.PCTargetE, 64'h210);
    tick();

    // Shifts use the low 6 bits of the amount (65 -> 1)
    drive(ALU_SLL, C_RW, FWD_RF, FWD_RF, 1'b1, 64'h8000_0000_0000_0001, 64'h0, 64'd65, 5'd2, 4'b0, 64'h0);
    push(64'h2, 64'h0, 5'd2, C_RW);
    tick();
    drive(ALU_SRL, C_RW, FWD_RF, FWD_RF, 1'b1, 64'h8000_0000_0000_0001, 64'h0, 64'd65, 5'd3, 4'b0, 64'h0);
    push(64'h4000_0000_0000_0000, 64'h0, 5'd3, C_RW);
    tick();

    // Store with data forwarded from M
    drive(ALU_ADD, C_STORE, FWD_RF, FWD_M, 1'b1, 64'h1000, 64'hDEAD, 64'd8, 5'd0, 4'b0, 64'h0);
    push(64'h1008, 64'h4000_0000_0000_0000, 5'd0, C_STORE);
    tick();

    // MUL -1 * 3 with A from W; W changes mid-stall and must not matter
    bus.ResultW = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(ALU_MUL, C_RW, FWD_W, FWD_RF, 1'b0, 64'h0, 64'd3, 64'h0, 5'd9, 4'b0, 64'h0);
    push(64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 5'd9, C_RW);
    #1;
    stall_cnt  = 0;
    bubble_bad = 0;
    while (bus.StallE === 1'b1 && stall_cnt < 200) begin
      stall_cnt++;
      if (stall_cnt > 1 && (m_ctl() != 5'b0 || bus.PCSrcE !== 1'b0)) bubble_bad++;
      if (stall_cnt == 5) bus.ResultW = 64'h0;
      tick();
    end
    chk("mul_stall_cycles", 64'(stall_cnt), 64'd65);
    chk("mul_bubbles", 64'(bubble_bad), 64'd0);
    tick();
    idle_e();
    repeat (2) tick();
    chk("after_mul_stall", 64'(bus.StallE), 64'h0);

    // Reset on the 20th MUL cycle aborts without a write
    drive(ALU_MUL, C_RW, FWD_RF, FWD_RF, 1'b0, 64'd5, 64'd7, 64'h0, 5'd10, 4'b0, 64'h0);
    tick();
    repeat (19) tick();
    reset = 1'b1;
    idle_e();
    tick();
    reset = 1'b0;
    #1;
    chk("mulrst_stall", 64'(bus.StallE), 64'h0);
    chk("mulrst_alu_m", bus.ALUResultM, 64'h0);
    chk("mulrst_ctl_m", 64'(m_ctl()), 64'h0);
    chk("mulrst_rd_m", 64'(bus.RD_M), 64'h0);

    drive(ALU_ADD, C_RW, FWD_RF, FWD_RF, 1'b0, 64'd1, 64'd1, 64'h0, 5'd11, 4'b0, 64'h0);
    push(64'd2, 64'd1, 5'd11, C_RW);
    tick();
    idle_e();
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
